pipe_hazard_ctrl: RTL and testbench

- Owns the four pipeline instruction latches (F/D, D/X, X/M, M/W) and the F/D and D/X PC latches of the 5-stage core.
- Produces fd_insn/dx_insn/xm_insn/mw_insn, which the forwarding unit and the datapath consume.
- Decides stalls for load-use hazards and for multiply/divide in flight.
- Decides flushes for taken branches and jumps resolved in X.
- Drives PC-enable and the multdiv start pulse.

---
 rtl/cpu_isa_pkg.sv | 64 ++++++
 rtl/insn_src_decode.sv | 51 +++++
 rtl/pipe_hazard_ctrl.sv | 117 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_isa_pkg.sv
// ISA constants and field helpers shared by the hazard controller, the
// forwarding unit and the datapath decoders.
package cpu_isa_pkg;

  localparam logic [31:0] NOP_INSN = 32'h0000_0000;

  localparam int OP_HI    = 31;
  localparam int OP_LO    = 27;
  localparam int RD_HI    = 26;
  localparam int RD_LO    = 22;
  localparam int RS_HI    = 21;
  localparam int RS_LO    = 17;
  localparam int RT_HI    = 16;
  localparam int RT_LO    = 12;
  localparam int ALUOP_HI = 6;
  localparam int ALUOP_LO = 2;

  localparam logic [4:0] R0  = 5'd0;
  localparam logic [4:0] R30 = 5'd30;
  localparam logic [4:0] R31 = 5'd31;

  localparam logic [4:0] OP_R    = 5'b00000;
  localparam logic [4:0] OP_J    = 5'b00001;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_JAL  = 5'b00011;
  localparam logic [4:0] OP_JR   = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_SETX = 5'b10101;
  localparam logic [4:0] OP_BEX  = 5'b10110;

  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;

  typedef enum logic {MD_IDLE, MD_BUSY} md_state_e;

  function automatic logic [4:0] insn_opcode(input logic [31:0] insn);
    return insn[OP_HI:OP_LO];
  endfunction

  function automatic logic [4:0] insn_rd(input logic [31:0] insn);
    return insn[RD_HI:RD_LO];
  endfunction

  function automatic logic [4:0] insn_rs(input logic [31:0] insn);
    return insn[RS_HI:RS_LO];
  endfunction

  function automatic logic [4:0] insn_rt(input logic [31:0] insn);
    return insn[RT_HI:RT_LO];
  endfunction

  function automatic logic [4:0] insn_aluop(input logic [31:0] insn);
    return insn[ALUOP_HI:ALUOP_LO];
  endfunction

  function automatic logic is_muldiv(input logic [31:0] insn);
    return (insn_opcode(insn) == OP_R) &&
           ((insn_aluop(insn) == ALU_MUL) || (insn_aluop(insn) == ALU_DIV));
  endfunction

endpackage

// File: rtl/insn_src_decode.sv
// Maps an instruction to the register numbers it reads, with a use flag per
// source so unused fields never raise a false hazard.
module insn_src_decode
  import cpu_isa_pkg::*;
(
  input  logic [31:0] insn,
  output logic [4:0]  src1,
  output logic [4:0]  src2,
  output logic        use1,
  output logic        use2
);

  logic unused_low_bits;
  assign unused_low_bits = ^insn[11:0];

  always_comb begin
    src1 = R0;
    src2 = R0;
    use1 = 1'b0;
    use2 = 1'b0;
    case (insn_opcode(insn))
      OP_R: begin
        src1 = insn_rs(insn);
        src2 = insn_rt(insn);
        use1 = 1'b1;
        use2 = 1'b1;
      end
      OP_ADDI, OP_LW: begin
        src1 = insn_rs(insn);
        use1 = 1'b1;
      end
      // Stores and compares read the rd field as a data source.
      OP_SW, OP_BNE, OP_BLT: begin
        src1 = insn_rd(insn);
        src2 = insn_rs(insn);
        use1 = 1'b1;
        use2 = 1'b1;
      end
      OP_JR: begin
        src1 = insn_rd(insn);
        use1 = 1'b1;
      end
      OP_BEX: begin
        src1 = R30;
        use1 = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline latch owner for the 5-stage core: load-use and multdiv stalls,
// X-stage branch flushes, PC enable and the multdiv start pulse.
module pipe_hazard_ctrl #(
  parameter int          PC_W     = 32,
  parameter logic [31:0] NOP_INSN = 32'h0000_0000
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [31:0]     imem_insn,
  input  logic [PC_W-1:0] pc_in,
  input  logic            branch_taken,
  input  logic            md_ready,
  output logic [31:0]     fd_insn,
  output logic [31:0]     dx_insn,
  output logic [31:0]     xm_insn,
  output logic [31:0]     mw_insn,
  output logic [PC_W-1:0] fd_pc,
  output logic [PC_W-1:0] dx_pc,
  output logic            pc_enable,
  output logic            stall,
  output logic            flush,
  output logic            md_start
);
  import cpu_isa_pkg::*;

  md_state_e  md_state, md_state_next;
  logic [4:0] fd_src1, fd_src2;
  logic       fd_use1, fd_use2;
  logic [4:0] dx_rd;
  logic       dx_is_md, dx_is_load, load_use;
  logic       md_go, md_stall, do_flush, do_load_use;

  insn_src_decode u_fd_src (
    .insn (fd_insn),
    .src1 (fd_src1),
    .src2 (fd_src2),
    .use1 (fd_use1),
    .use2 (fd_use2)
  );

  assign dx_rd      = insn_rd(dx_insn);
  assign dx_is_md   = is_muldiv(dx_insn);
  assign dx_is_load = (insn_opcode(dx_insn) == OP_LW) && (dx_rd != R0);
  assign load_use   = dx_is_load &&
                      ((fd_use1 && (fd_src1 == dx_rd)) || (fd_use2 && (fd_src2 == dx_rd)));

  // Multdiv holds the front end from the cycle it is seen in D/X until the
  // cycle md_ready arrives; that cycle D/X is released.
  always_comb begin
    md_state_next = md_state;
    md_go         = 1'b0;
    md_stall      = 1'b0;
    case (md_state)
      MD_IDLE: begin
        if (dx_is_md) begin
          md_state_next = MD_BUSY;
          md_go         = 1'b1;
          md_stall      = 1'b1;
        end
      end
      MD_BUSY: begin
        if (md_ready) md_state_next = MD_IDLE;
        else          md_stall      = 1'b1;
      end
      default: md_state_next = MD_IDLE;
    endcase
  end

  assign do_flush    = branch_taken && !md_stall;
  assign do_load_use = load_use && !md_stall && !do_flush;

  always_comb begin
    pc_enable = 1'b0;
    stall     = 1'b0;
    flush     = 1'b0;
    md_start  = 1'b0;
    if (!reset) begin
      stall     = md_stall || do_load_use;
      flush     = do_flush;
      pc_enable = !(md_stall || do_load_use);
      md_start  = md_go;
    end
  end

  // PC latches hold on flush; the bubbled stages make their values moot.
  always_ff @(posedge clock) begin
    if (reset) begin
      fd_insn  <= NOP_INSN;
      dx_insn  <= NOP_INSN;
      xm_insn  <= NOP_INSN;
      mw_insn  <= NOP_INSN;
      fd_pc    <= '0;
      dx_pc    <= '0;
      md_state <= MD_IDLE;
    end else begin
      md_state <= md_state_next;
      mw_insn  <= xm_insn;
      if (do_flush) begin
        fd_insn <= NOP_INSN;
        dx_insn <= NOP_INSN;
        xm_insn <= dx_insn;
      end else if (md_stall) begin
        xm_insn <= NOP_INSN;
      end else if (do_load_use) begin
        dx_insn <= NOP_INSN;
        xm_insn <= dx_insn;
      end else begin
        fd_insn <= imem_insn;
        fd_pc   <= pc_in;
        dx_insn <= fd_insn;
        dx_pc   <= fd_pc;
        xm_insn <= dx_insn;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: fixed vector table, hand-built
// multi-cycle sequences and a randomized run against a pipeline model.
module tb_pipe_hazard_ctrl;

  localparam int PC_W = 32;

  localparam logic [4:0] OPC_R    = 5'd0;
  localparam logic [4:0] OPC_J    = 5'd1;
  localparam logic [4:0] OPC_BNE  = 5'd2;
  localparam logic [4:0] OPC_JAL  = 5'd3;
  localparam logic [4:0] OPC_JR   = 5'd4;
  localparam logic [4:0] OPC_ADDI = 5'd5;
  localparam logic [4:0] OPC_BLT  = 5'd6;
  localparam logic [4:0] OPC_SW   = 5'd7;
  localparam logic [4:0] OPC_LW   = 5'd8;
  localparam logic [4:0] OPC_SETX = 5'd21;
  localparam logic [4:0] OPC_BEX  = 5'd22;
  localparam logic [31:0] NOP     = 32'h0;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [31:0]     imem_insn = '0;
  logic [PC_W-1:0] pc_in = '0;
  logic            branch_taken = 1'b0;
  logic            md_ready = 1'b0;
  logic [31:0]     fd_insn, dx_insn, xm_insn, mw_insn;
  logic [PC_W-1:0] fd_pc, dx_pc;
  logic            pc_enable, stall, flush, md_start;

  pipe_hazard_ctrl #(.PC_W(PC_W), .NOP_INSN(32'h0)) dut (
    .clock        (clock),
    .reset        (reset),
    .imem_insn    (imem_insn),
    .pc_in        (pc_in),
    .branch_taken (branch_taken),
    .md_ready     (md_ready),
    .fd_insn      (fd_insn),
    .dx_insn      (dx_insn),
    .xm_insn      (xm_insn),
    .mw_insn      (mw_insn),
    .fd_pc        (fd_pc),
    .dx_pc        (dx_pc),
    .pc_enable    (pc_enable),
    .stall        (stall),
    .flush        (flush),
    .md_start     (md_start)
  );

  always #5 clock = ~clock;

  int vec_count  = 0;
  int miss_count = 0;

  // Pipeline model: four stage slots, PC slots with a "meaningful" flag,
  // and one bit for a multdiv operation in flight.
  logic [31:0]     m_fd, m_dx, m_xm, m_mw;
  logic [PC_W-1:0] m_fd_pc, m_dx_pc;
  bit              m_fd_pc_ok, m_dx_pc_ok, m_busy;
  bit              m_valid = 1'b0;
  bit              e_md_stall, e_flush, e_load_use;

  logic [PC_W-1:0] pc_ctr = '0;
  logic [31:0]     s_fd, s_dx, s_xm, s_mw;
  logic            s_stall, s_flush, s_pce, s_mds;
  int              stall_cnt, mds_cnt;

  typedef struct {
    logic [31:0] imem;
    logic [31:0] fd, dx, xm, mw;
    logic        stall, pce;
  } vec_t;
  vec_t tbl[18];

  function automatic logic [31:0] r_ins(input logic [4:0] rd, rs, rt, aluop);
    return {OPC_R, rd, rs, rt, 5'd0, aluop, 2'b00};
  endfunction

  function automatic logic [31:0] i_ins(input logic [4:0] op, rd, rs, input logic [16:0] imm);
    return {op, rd, rs, imm};
  endfunction

  function automatic bit is_md(input logic [31:0] i);
    return (i[31:27] == OPC_R) && ((i[6:2] == 5'd6) || (i[6:2] == 5'd7));
  endfunction

  function automatic bit reads_reg(input logic [31:0] i, input logic [4:0] r);
    logic [4:0] rd, rs, rt;
    rd = i[26:22];
    rs = i[21:17];
    rt = i[16:12];
    case (i[31:27])
      OPC_R:                     return (rs == r) || (rt == r);
      OPC_ADDI, OPC_LW:          return rs == r;
      OPC_SW, OPC_BNE, OPC_BLT:  return (rd == r) || (rs == r);
      OPC_JR:                    return rd == r;
      OPC_BEX:                   return r == 5'd30;
      default:                   return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] rand_insn();
    logic [4:0] a, b, c;
    a = 5'($urandom_range(0, 3));
    b = 5'($urandom_range(0, 3));
    c = 5'($urandom_range(0, 3));
    case ($urandom_range(0, 9))
      0, 1:    return r_ins(a, b, c, 5'd0);
      2:       return r_ins(a, b, c, 5'($urandom_range(6, 7)));
      3, 4:    return i_ins(OPC_LW, a, b, 17'd0);
      5:       return i_ins(OPC_SW, a, b, 17'd4);
      6:       return i_ins(($urandom_range(0, 1) == 0) ? OPC_BNE : OPC_BLT, a, b, 17'd2);
      7:       return i_ins(OPC_JR, a, 5'd0, 17'd0);
      8: begin
        case ($urandom_range(0, 3))
          0:       return {OPC_BEX, 27'd16};
          1:       return {OPC_J, 27'd64};
          2:       return {OPC_JAL, 27'd32};
          default: return {OPC_SETX, 27'd7};
        endcase
      end
      default: return i_ins(OPC_ADDI, a, b, 17'd5);
    endcase
  endfunction

  task automatic check_value(input string name, input logic [255:0] act, input logic [255:0] exp);
    vec_count++;
    if (act !== exp) begin
      miss_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input bit rst, input bit bt, input bit mdr);
    bit stall_e, pce_e, mds_e, flush_e;
    logic [4:0] ld_rd;
    ld_rd      = m_dx[26:22];
    e_md_stall = (!m_busy && is_md(m_dx)) || (m_busy && !mdr);
    e_flush    = bt && !e_md_stall;
    e_load_use = !e_md_stall && !e_flush && (m_dx[31:27] == OPC_LW) &&
                 (ld_rd != 5'd0) && reads_reg(m_fd, ld_rd);
    stall_e = !rst && (e_md_stall || e_load_use);
    flush_e = !rst && e_flush;
    pce_e   = !rst && !(e_md_stall || e_load_use);
    mds_e   = !rst && !m_busy && is_md(m_dx);
    if (m_valid)
      check_value("model",
        {fd_insn, dx_insn, xm_insn, mw_insn,
         m_fd_pc_ok ? fd_pc : '0, m_dx_pc_ok ? dx_pc : '0,
         stall, flush, pc_enable, md_start},
        {m_fd, m_dx, m_xm, m_mw,
         m_fd_pc_ok ? m_fd_pc : '0, m_dx_pc_ok ? m_dx_pc : '0,
         stall_e, flush_e, pce_e, mds_e});
  endtask

  task automatic model_step(input bit rst, input logic [31:0] insn, input logic [PC_W-1:0] pc, input bit mdr);
    bit busy_n;
    if (rst) begin
      m_fd = NOP; m_dx = NOP; m_xm = NOP; m_mw = NOP;
      m_fd_pc = '0; m_dx_pc = '0; m_fd_pc_ok = 1'b1; m_dx_pc_ok = 1'b1;
      m_busy = 1'b0; m_valid = 1'b1;
      return;
    end
    busy_n = m_busy ? !mdr : is_md(m_dx);
    m_mw = m_xm;
    if (e_flush) begin
      m_xm = m_dx; m_dx = NOP; m_fd = NOP;
      m_fd_pc_ok = 1'b0; m_dx_pc_ok = 1'b0;
    end else if (e_md_stall) begin
      m_xm = NOP;
    end else if (e_load_use) begin
      m_xm = m_dx; m_dx = NOP; m_dx_pc_ok = 1'b0;
    end else begin
      m_xm = m_dx;
      m_dx = m_fd; m_dx_pc = m_fd_pc; m_dx_pc_ok = m_fd_pc_ok;
      m_fd = insn; m_fd_pc = pc;      m_fd_pc_ok = 1'b1;
    end
    m_busy = busy_n;
  endtask

  task automatic applyStimulus(input bit rst, input logic [31:0] insn, input bit bt, input bit mdr);
    @(negedge clock);
    reset = rst; imem_insn = insn; pc_in = pc_ctr; branch_taken = bt; md_ready = mdr;
    #1;
    checkOutput(rst, bt, mdr);
    s_fd = fd_insn; s_dx = dx_insn; s_xm = xm_insn; s_mw = mw_insn;
    s_stall = stall; s_flush = flush; s_pce = pc_enable; s_mds = md_start;
    @(posedge clock);
    model_step(rst, insn, pc_ctr, mdr);
    pc_ctr = pc_ctr + 4;
  endtask

  task automatic set_row(input int idx, input logic [31:0] imem, fd, dx, xm, mw, input logic st, pce);
    tbl[idx].imem = imem; tbl[idx].fd = fd; tbl[idx].dx = dx;
    tbl[idx].xm = xm; tbl[idx].mw = mw; tbl[idx].stall = st; tbl[idx].pce = pce;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] addi1, add2, lw3, add4, lw0, add4z, lw30, bex, mul, mul2, bne, dep;
    addi1 = i_ins(OPC_ADDI, 5'd1, 5'd0, 17'd5);
    add2  = r_ins(5'd2, 5'd1, 5'd1, 5'd0);
    lw3   = i_ins(OPC_LW, 5'd3, 5'd1, 17'd0);
    add4  = r_ins(5'd4, 5'd3, 5'd2, 5'd0);
    lw0   = i_ins(OPC_LW, 5'd0, 5'd1, 17'd0);
    add4z = r_ins(5'd4, 5'd0, 5'd2, 5'd0);
    lw30  = i_ins(OPC_LW, 5'd30, 5'd0, 17'd0);
    bex   = {OPC_BEX, 27'd100};
    mul   = r_ins(5'd5, 5'd1, 5'd2, 5'd6);
    mul2  = r_ins(5'd6, 5'd3, 5'd4, 5'd7);
    bne   = i_ins(OPC_BNE, 5'd1, 5'd2, 17'd8);
    dep   = r_ins(5'd5, 5'd3, 5'd3, 5'd0);

    set_row( 0, addi1, NOP,   NOP,   NOP,   NOP,   1'b0, 1'b1);
    set_row( 1, add2,  addi1, NOP,   NOP,   NOP,   1'b0, 1'b1);
    set_row( 2, NOP,   add2,  addi1, NOP,   NOP,   1'b0, 1'b1);
    set_row( 3, NOP,   NOP,   add2,  addi1, NOP,   1'b0, 1'b1);
    set_row( 4, NOP,   NOP,   NOP,   add2,  addi1, 1'b0, 1'b1);
    set_row( 5, lw3,   NOP,   NOP,   NOP,   add2,  1'b0, 1'b1);
    set_row( 6, add4,  lw3,   NOP,   NOP,   NOP,   1'b0, 1'b1);
    set_row( 7, NOP,   add4,  lw3,   NOP,   NOP,   1'b1, 1'b0);
    set_row( 8, NOP,   add4,  NOP,   lw3,   NOP,   1'b0, 1'b1);
    set_row( 9, NOP,   NOP,   add4,  NOP,   lw3,   1'b0, 1'b1);
    set_row(10, lw0,   NOP,   NOP,   add4,  NOP,   1'b0, 1'b1);
    set_row(11, add4z, lw0,   NOP,   NOP,   add4,  1'b0, 1'b1);
    set_row(12, NOP,   add4z, lw0,   NOP,   NOP,   1'b0, 1'b1);
    set_row(13, NOP,   NOP,   add4z, lw0,   NOP,   1'b0, 1'b1);
    set_row(14, lw30,  NOP,   NOP,   add4z, lw0,   1'b0, 1'b1);
    set_row(15, bex,   lw30,  NOP,   NOP,   add4z, 1'b0, 1'b1);
    set_row(16, NOP,   bex,   lw30,  NOP,   NOP,   1'b1, 1'b0);
    set_row(17, NOP,   bex,   NOP,   lw30,  NOP,   1'b0, 1'b1);

    applyStimulus(1'b1, NOP, 1'b0, 1'b0);
    applyStimulus(1'b1, NOP, 1'b0, 1'b1);
    check_value("reset_comb_outputs", {s_pce, s_stall, s_flush, s_mds}, 4'b0000);

    for (int i = 0; i < 18; i++) begin
      applyStimulus(1'b0, tbl[i].imem, 1'b0, 1'b0);
      check_value($sformatf("table_row%0d", i),
        {s_fd, s_dx, s_xm, s_mw, s_stall, s_flush, s_pce, s_mds},
        {tbl[i].fd, tbl[i].dx, tbl[i].xm, tbl[i].mw, tbl[i].stall, 1'b0, tbl[i].pce, 1'b0});
    end

    $display("[TB] multdiv single");
    applyStimulus(1'b0, mul, 1'b0, 1'b0);
    applyStimulus(1'b0, NOP, 1'b0, 1'b0);
    stall_cnt = 0; mds_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, NOP, 1'b0, i == 6);
      stall_cnt += int'(s_stall);
      mds_cnt   += int'(s_mds);
      if (i == 3) check_value("md_xm_bubble", s_xm, NOP);
    end
    check_value("md_stall_cycles", stall_cnt, 6);
    check_value("md_start_pulses", mds_cnt, 1);
    applyStimulus(1'b0, NOP, 1'b0, 1'b1);
    check_value("md_in_xm_after_ready", s_xm, mul);

    $display("[TB] multdiv back to back");
    applyStimulus(1'b0, mul, 1'b0, 1'b0);
    applyStimulus(1'b0, mul2, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, NOP, i == 1, i == 3);
      if (i == 1) check_value("branch_ignored_busy", {s_flush, s_stall}, 2'b01);
    end
    applyStimulus(1'b0, NOP, 1'b0, 1'b0);
    check_value("b2b_md_start", {s_mds, s_dx}, {1'b1, mul2});
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, NOP, 1'b0, i == 2);

    $display("[TB] branch flush");
    applyStimulus(1'b0, bne, 1'b0, 1'b0);
    applyStimulus(1'b0, addi1, 1'b0, 1'b0);
    applyStimulus(1'b0, add2, 1'b1, 1'b0);
    check_value("flush_asserted", {s_flush, s_stall, s_pce}, 3'b101);
    applyStimulus(1'b0, NOP, 1'b0, 1'b0);
    check_value("flush_result", {s_fd, s_dx, s_xm}, {NOP, NOP, bne});

    $display("[TB] flush over load-use");
    applyStimulus(1'b0, lw3, 1'b0, 1'b0);
    applyStimulus(1'b0, dep, 1'b0, 1'b0);
    applyStimulus(1'b0, NOP, 1'b1, 1'b0);
    check_value("flush_beats_loaduse", {s_flush, s_stall, s_pce}, 3'b101);
    applyStimulus(1'b0, NOP, 1'b0, 1'b0);
    check_value("loaduse_discarded", {s_fd, s_dx, s_xm}, {NOP, NOP, lw3});

    $display("[TB] reset mid-busy");
    applyStimulus(1'b0, mul, 1'b0, 1'b0);
    applyStimulus(1'b0, NOP, 1'b0, 1'b0);
    applyStimulus(1'b0, NOP, 1'b0, 1'b0);
    applyStimulus(1'b0, NOP, 1'b0, 1'b0);
    applyStimulus(1'b0, NOP, 1'b0, 1'b0);
    applyStimulus(1'b1, NOP, 1'b0, 1'b0);
    applyStimulus(1'b0, NOP, 1'b0, 1'b1);
    check_value("reset_clears_busy", {s_fd, s_dx, s_xm, s_mw, s_stall, s_mds, s_pce},
                {NOP, NOP, NOP, NOP, 1'b0, 1'b0, 1'b1});
    applyStimulus(1'b0, addi1, 1'b0, 1'b1);
    check_value("late_md_ready_ignored", {s_stall, s_mds}, 2'b00);

    $display("[TB] random run");
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) pc_ctr = PC_W'($urandom) & ~PC_W'(3);
      applyStimulus($urandom_range(0, 99) == 0, rand_insn(),
                    $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
